shift_serializer: RTL and testbench

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

---
 rtl/shift_serializer.sv | 117 +++++++++++
 tb/tb_shift_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_serializer.sv
// shift_serializer: turns an N-bit parallel word into a serial bit stream
// with a valid strobe (shift_en) and an end-of-word pulse (word_done).
// A valid/ready handshake loads the word. An optional run of GAP idle
// cycles is inserted after each word.
`timescale 1ns/1ps

module shift_serializer #(
    parameter int N         = 3,  // word width, N >= 2
    parameter int GAP       = 0,  // idle cycles after each word, 0..255
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    output logic         serial_out,
    output logic         shift_en,
    output logic         word_done,
    output logic         busy
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam bit            HAS_GAP  = (GAP > 0);
    localparam logic [7:0]    GAP_LAST = HAS_GAP ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;    // index of the bit on the line
    logic [7:0]    gap_q, gap_d;    // idle cycles already spent in ST_GAP
    logic [N-1:0]  hold_q, hold_d;  // word in flight, isolated from data_in
    logic          rdy_en_q;        // keeps data_ready low until the first edge after reset

    logic          last_bit;
    logic          xfer;
    logic [CW-1:0] bit_idx;

    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign xfer     = data_valid && data_ready;
    assign bit_idx  = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);

    // Outputs decode straight from state. An asynchronous reset of the
    // state therefore clears them at once, with no clock edge needed.
    assign shift_en   = (state_q == ST_SHIFT);
    assign word_done  = last_bit;
    assign busy       = (state_q != ST_IDLE);
    assign serial_out = shift_en && hold_q[bit_idx];
    // With no gap, the last bit cycle may accept the next word so words run back to back.
    assign data_ready = rdy_en_q && ((state_q == ST_IDLE) || (!HAS_GAP && last_bit));

    // Next-state logic: handshake loads, bit stepping, gap countdown.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    hold_d  = data_in;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    if (HAS_GAP) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else if (xfer) begin
                        cnt_d  = '0;
                        hold_d = data_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            // NOTE: the holding register is reset as well, so a discarded word never leaks out later.
            hold_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            hold_q   <= hold_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: directed bench for three serializer instances
// (lane 0: GAP=0 LSB first, lane 1: GAP=2 LSB first, lane 2: GAP=0 MSB first).
// Expected bits are queued when a word is offered. Each cycle, the bits are
// popped and compared as the lanes raise shift_en.
`timescale 1ns/1ps

module tb_shift_serializer;

    typedef struct {
        int   lane;
        logic b;
        logic last;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [2:0] d0, d1, d2;
    logic [2:0] v;
    logic [2:0] dr, so, se, wd, bz;
    logic [2:0] ds0, ds1, ds2;     // downstream shift registers

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_err    = 0;
    int         sh_cnt[3];
    int         wd_cnt[3];
    int         b_sh, b_wd;

    shift_serializer #(.N(3), .GAP(0), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .data_in(d0), .data_valid(v[0]),
        .data_ready(dr[0]), .serial_out(so[0]), .shift_en(se[0]),
        .word_done(wd[0]), .busy(bz[0])
    );

    shift_serializer #(.N(3), .GAP(2), .LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(d1), .data_valid(v[1]),
        .data_ready(dr[1]), .serial_out(so[1]), .shift_en(se[1]),
        .word_done(wd[1]), .busy(bz[1])
    );

    shift_serializer #(.N(3), .GAP(0), .LSB_FIRST(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .data_in(d2), .data_valid(v[2]),
        .data_ready(dr[2]), .serial_out(so[2]), .shift_en(se[2]),
        .word_done(wd[2]), .busy(bz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream receivers: LSB-first lanes shift right, MSB-first lane shifts left.
    always @(posedge clk) begin
        if (se[0]) ds0 <= {so[0], ds0[2:1]};
        if (se[1]) ds1 <= {so[1], ds1[2:1]};
        if (se[2]) ds2 <= {ds2[1:0], so[2]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int lane, input logic [2:0] w);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.lane = lane;
            e.b    = (lane == 2) ? w[2 - i] : w[i];
            e.last = (i == 2);
            sb_q.push_back(e);
        end
    endtask

    // Advance one clock, then score every lane in the new cycle.
    task automatic step();
        exp_t e;
        int   front;
        @(posedge clk);
        #1;
        for (int l = 0; l < 3; l++) begin
            if (se[l]) begin
                sh_cnt[l]++;
                if (wd[l]) wd_cnt[l]++;
                front = (sb_q.size() > 0) ? sb_q[0].lane : -1;
                check($sformatf("lane%0d_shift_expected", l), front, l);
                if (front == l) begin
                    e = sb_q.pop_front();
                    check($sformatf("lane%0d_serial_bit", l), so[l], e.b);
                    check($sformatf("lane%0d_word_done", l), wd[l], e.last);
                end
            end else begin
                check($sformatf("lane%0d_idle_serial_zero", l), so[l], 1'b0);
                check($sformatf("lane%0d_idle_no_word_done", l), wd[l], 1'b0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        v = '0; d0 = '0; d1 = '0; d2 = '0;
        for (int l = 0; l < 3; l++) begin sh_cnt[l] = 0; wd_cnt[l] = 0; end

        // Reset state
        #1;
        check("reset_outputs", {se, so, wd, bz, dr}, 15'd0);
        step(); step();
        check("reset_outputs_held", {se, so, wd, bz, dr}, 15'd0);
        #3 reset_n = 1'b1;
        step();
        check("ready_after_reset", dr, 3'b111);
        check("idle_after_reset", bz, 3'b000);

        // Single word 101, LSB first
        b_sh = sh_cnt[0]; b_wd = wd_cnt[0];
        d0 = 3'b101; v[0] = 1'b1; push_word(0, 3'b101);
        step(); v[0] = 1'b0;
        check("t1_busy", bz[0], 1'b1);
        check("t1_not_ready_mid_word", dr[0], 1'b0);
        repeat (3) step();
        check("t1_shift_cycles", sh_cnt[0] - b_sh, 3);
        check("t1_word_done_count", wd_cnt[0] - b_wd, 1);
        check("t1_downstream_word", ds0, 3'b101);
        check("t1_queue_drained", sb_q.size(), 0);
        check("t1_back_to_idle", {bz[0], dr[0]}, 2'b01);

        // Back-to-back 110 then 011 with valid held
        b_wd = wd_cnt[0];
        d0 = 3'b110; v[0] = 1'b1;
        push_word(0, 3'b110); push_word(0, 3'b011);
        step(); d0 = 3'b011;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_shift_en_cycle%0d", i + 1), se[0], 1'b1);
            if (i == 2) check("t2_ready_on_last_bit", dr[0], 1'b1);
            if (i == 3) v[0] = 1'b0;
            step();
        end
        check("t2_stream_ends", se[0], 1'b0);
        check("t2_word_done_count", wd_cnt[0] - b_wd, 2);
        check("t2_downstream_word", ds0, 3'b011);
        check("t2_queue_drained", sb_q.size(), 0);

        // data_in changes during SHIFT; the new word waits for its own handshake
        d0 = 3'b101; v[0] = 1'b1; push_word(0, 3'b101);
        step(); d0 = 3'b010; v[0] = 1'b0;
        step(); v[0] = 1'b1;
        check("t3_not_ready_mid_word", dr[0], 1'b0);
        push_word(0, 3'b010);
        step();
        check("t3_ready_on_last_bit", dr[0], 1'b1);
        step(); v[0] = 1'b0;
        repeat (3) step();
        check("t3_downstream_word", ds0, 3'b010);
        check("t3_queue_drained", sb_q.size(), 0);
        check("t3_idle", bz[0], 1'b0);

        // Reset after the second bit of 011 (bits 1,1 sent, third discarded)
        b_wd = wd_cnt[0];
        d0 = 3'b011; v[0] = 1'b1;
        sb_q.push_back('{0, 1'b1, 1'b0});
        sb_q.push_back('{0, 1'b1, 1'b0});
        step(); v[0] = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        check("t4_async_reset_outputs", {se, so, wd, bz, dr}, 15'd0);
        step(); step();
        check("t4_no_word_done", wd_cnt[0] - b_wd, 0);
        check("t4_queue_drained", sb_q.size(), 0);
        #3 reset_n = 1'b1;
        step();
        check("t4_ready_after_release", dr, 3'b111);
        d0 = 3'b110; v[0] = 1'b1; push_word(0, 3'b110);
        step(); v[0] = 1'b0;
        repeat (3) step();
        check("t4_downstream_word", ds1 === ds1 ? ds0 : 3'bx, 3'b110);
        check("t4_queue_drained_after", sb_q.size(), 0);

        // GAP=2 lane: two words with valid held
        d1 = 3'b101; v[1] = 1'b1; push_word(1, 3'b101);
        step(); d1 = 3'b010; push_word(1, 3'b010);
        step(); step();
        check("t5_no_ready_on_last_bit", dr[1], 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("t5_gap%0d_shift_en", i), se[1], 1'b0);
            check($sformatf("t5_gap%0d_ready", i), dr[1], 1'b0);
            check($sformatf("t5_gap%0d_busy", i), bz[1], 1'b1);
        end
        step();
        check("t5_ready_after_gap", dr[1], 1'b1);
        check("t5_idle_no_shift", se[1], 1'b0);
        step(); v[1] = 1'b0;
        check("t5_second_word_starts", se[1], 1'b1);
        repeat (3) step();
        check("t5_downstream_word", ds1, 3'b010);
        check("t5_queue_drained", sb_q.size(), 0);
        repeat (2) step();
        check("t5_back_to_idle", {bz[1], dr[1]}, 2'b01);

        // MSB-first lane: word 100 -> 1,0,0
        b_wd = wd_cnt[2];
        d2 = 3'b100; v[2] = 1'b1; push_word(2, 3'b100);
        step(); v[2] = 1'b0;
        repeat (3) step();
        check("t6_downstream_word", ds2, 3'b100);
        check("t6_word_done_count", wd_cnt[2] - b_wd, 1);
        check("t6_queue_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
